// File: rtl/spare_sig_checker_pkg.sv
// Shared encodings, limits and state type for the spare-structure
// signature checker.
package spare_sig_checker_pkg;

  localparam logic [1:0] TYPE_OFF = 2'b00;
  localparam logic [1:0] TYPE_S1  = 2'b01;
  localparam logic [1:0] TYPE_S2  = 2'b10;
  localparam logic [1:0] TYPE_S3  = 2'b11;

  localparam int CNT_S12 = 70;
  localparam int CNT_S3  = 210;

  localparam logic [7:0] FIRST_DSSS = 8'hF0;
  localparam logic [7:0] LAST_DSSS  = 8'h0F;
  localparam logic [3:0] FIRST_RLSS = 4'b1000;
  localparam logic [3:0] LAST_RLSS  = 4'b0010;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_POP   = 2'b01;
  localparam logic [1:0] ERR_RLSS  = 2'b10;
  localparam logic [1:0] ERR_ORDER = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE,
    S_ERR
  } state_e;

  function automatic logic [1:0] rlss_pos(
    input logic [3:0] r
  );
    logic [1:0] pos;
    pos = 2'd0;
    if (r[3])      pos = 2'd3;
    else if (r[2]) pos = 2'd2;
    else if (r[1]) pos = 2'd1;
    return pos;
  endfunction

endpackage

// File: rtl/spare_sig_checker_dsss_index_extract.sv
// Finds the four highest set-bit positions of a pattern word
// (descending) and its popcount.
module dsss_index_extract
  import spare_sig_checker_pkg::*;
(
  input  logic [7:0] dsss_i,
  output logic [2:0] idx_i_o,
  output logic [2:0] idx_j_o,
  output logic [2:0] idx_k_o,
  output logic [2:0] idx_p_o,
  output logic [3:0] pop_o
);

  logic [3:0] cnt;

  always_comb begin
    cnt     = 4'd0;
    idx_i_o = 3'd0;
    idx_j_o = 3'd0;
    idx_k_o = 3'd0;
    idx_p_o = 3'd0;
    for (int b = 7; b >= 0; b--) begin
      if (dsss_i[b]) begin
        case (cnt)
          4'd0:    idx_i_o = 3'(b);
          4'd1:    idx_j_o = 3'(b);
          4'd2:    idx_k_o = 3'(b);
          4'd3:    idx_p_o = 3'(b);
          default: ;
        endcase
        cnt = cnt + 4'd1;
      end
    end
    pop_o = cnt;
  end

endmodule

// File: rtl/spare_sig_checker.sv
// Receive-side checker: decodes DSSS/RLSS beats into indices and
// verifies popcount, RLSS legality and strict generation order.
module spare_sig_checker
  import spare_sig_checker_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [1:0]       spare_struct_type,
  input  logic [7:0]       DSSS,
  input  logic [3:0]       RLSS,
  output logic             dec_valid,
  output logic [2:0]       idx_i,
  output logic [2:0]       idx_j,
  output logic [2:0]       idx_k,
  output logic [2:0]       idx_p,
  output logic [1:0]       idx_ri,
  output logic [CNT_W-1:0] combo_cnt,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code
);

  state_e           state_q, state_d;
  logic [1:0]       type_q, type_d;
  logic [7:0]       prev_q, prev_d;
  logic [1:0]       ri_q, ri_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             vld_q, vld_d;
  logic [2:0]       i_q, i_d;
  logic [2:0]       j_q, j_d;
  logic [2:0]       k_q, k_d;
  logic [2:0]       p_q, p_d;
  logic [1:0]       ecode_q, ecode_d;

  logic [2:0]       ex_i, ex_j, ex_k, ex_p;
  logic [3:0]       pop;

  dsss_index_extract u_extract (
    .dsss_i  (DSSS),
    .idx_i_o (ex_i),
    .idx_j_o (ex_j),
    .idx_k_o (ex_k),
    .idx_p_o (ex_p),
    .pop_o   (pop)
  );

  logic             beat;
  logic             is_s3;
  logic [1:0]       ri_in;
  logic             rlss_ok;
  logic             order_ok;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] exp_len;
  logic             last;

  assign beat    = (DSSS != 8'h00) &&
                   (spare_struct_type != TYPE_OFF);
  assign is_s3   = spare_struct_type == TYPE_S3;
  assign ri_in   = rlss_pos(RLSS);
  assign rlss_ok = is_s3 ? (!RLSS[0] && $onehot(RLSS[3:1]))
                         : (RLSS == 4'b0000);
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign exp_len = is_s3 ? CNT_W'(CNT_S3) : CNT_W'(CNT_S12);
  assign last    = (cnt_inc == exp_len) &&
                   (DSSS == LAST_DSSS) &&
                   (!is_s3 || RLSS == LAST_RLSS);

  // S3 repeats each pattern with ri 3,2,1 before it may step down
  always_comb begin
    order_ok = 1'b0;
    if (state_q == S_IDLE)
      order_ok = (DSSS == FIRST_DSSS) &&
                 (!is_s3 || RLSS == FIRST_RLSS);
    else if (spare_struct_type != type_q)
      order_ok = 1'b0;
    else if (!is_s3)
      order_ok = DSSS < prev_q;
    else if (ri_q != 2'd1)
      order_ok = (DSSS == prev_q) &&
                 (ri_in == ri_q - 2'd1);
    else
      order_ok = (DSSS < prev_q) && (ri_in == 2'd3);
  end

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    prev_d  = prev_q;
    ri_d    = ri_q;
    cnt_d   = cnt_q;
    vld_d   = 1'b0;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    p_d     = p_q;
    ecode_d = ecode_q;
    if (clr) begin
      state_d = S_IDLE;
      type_d  = TYPE_OFF;
      prev_d  = 8'h00;
      ri_d    = 2'd0;
      cnt_d   = '0;
      i_d     = 3'd0;
      j_d     = 3'd0;
      k_d     = 3'd0;
      p_d     = 3'd0;
      ecode_d = ERR_NONE;
    end else begin
      unique case (state_q)
        S_IDLE, S_RUN: begin
          if (beat) begin
            if (pop != 4'd4) begin
              state_d = S_ERR;
              ecode_d = ERR_POP;
            end else if (!rlss_ok) begin
              state_d = S_ERR;
              ecode_d = ERR_RLSS;
            end else if (!order_ok) begin
              state_d = S_ERR;
              ecode_d = ERR_ORDER;
            end else begin
              vld_d   = 1'b1;
              i_d     = ex_i;
              j_d     = ex_j;
              k_d     = ex_k;
              p_d     = ex_p;
              ri_d    = is_s3 ? ri_in : 2'd0;
              prev_d  = DSSS;
              cnt_d   = cnt_inc;
              type_d  = spare_struct_type;
              state_d = last ? S_DONE : S_RUN;
            end
          end
        end
        S_DONE, S_ERR: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      type_q  <= TYPE_OFF;
      prev_q  <= 8'h00;
      ri_q    <= 2'd0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      i_q     <= 3'd0;
      j_q     <= 3'd0;
      k_q     <= 3'd0;
      p_q     <= 3'd0;
      ecode_q <= ERR_NONE;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      prev_q  <= prev_d;
      ri_q    <= ri_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      p_q     <= p_d;
      ecode_q <= ecode_d;
    end
  end

  assign dec_valid = vld_q;
  assign idx_i     = i_q;
  assign idx_j     = j_q;
  assign idx_k     = k_q;
  assign idx_p     = p_q;
  assign idx_ri    = ri_q;
  assign combo_cnt = cnt_q;
  assign done      = state_q == S_DONE;
  assign err       = state_q == S_ERR;
  assign err_code  = ecode_q;

endmodule

// File: tb/tb_spare_sig_checker.sv
// Directed bench for spare_sig_checker: full S1/S3 streams and
// injected popcount, RLSS, order, reset and clear cases.
module tb_spare_sig_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic [1:0] spare_struct_type = 2'b00;
  logic [7:0] DSSS = 8'h00;
  logic [3:0] RLSS = 4'h0;
  logic       dec_valid;
  logic [2:0] idx_i, idx_j, idx_k, idx_p;
  logic [1:0] idx_ri;
  logic [7:0] combo_cnt;
  logic       done, err;
  logic [1:0] err_code;

  int n_chk = 0;
  int n_err = 0;
  int pulses;
  logic [7:0] pats[$];

  always #5 clk = ~clk;

  spare_sig_checker #(.CNT_W(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .clr               (clr),
    .spare_struct_type (spare_struct_type),
    .DSSS              (DSSS),
    .RLSS              (RLSS),
    .dec_valid         (dec_valid),
    .idx_i             (idx_i),
    .idx_j             (idx_j),
    .idx_k             (idx_k),
    .idx_p             (idx_p),
    .idx_ri            (idx_ri),
    .combo_cnt         (combo_cnt),
    .done              (done),
    .err               (err),
    .err_code          (err_code)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] t,
                       input logic [7:0] d,
                       input logic [3:0] r);
    spare_struct_type = t;
    DSSS = d;
    RLSS = r;
    @(posedge clk);
    #1;
    if (dec_valid) pulses++;
  endtask

  task automatic do_clr();
    DSSS = 8'h00;
    RLSS = 4'h0;
    clr  = 1'b1;
    @(posedge clk);
    #1;
    clr  = 1'b0;
    pulses = 0;
  endtask

  function automatic logic [11:0] idx4();
    return {idx_i, idx_j, idx_k, idx_p};
  endfunction

  initial begin
    logic [11:0] first_idx, last_idx;
    int ri_bad;

    for (int v = 255; v > 0; v--) begin
      logic [7:0] b;
      b = v[7:0];
      if ($countones(b) == 4) pats.push_back(b);
    end

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(dec_valid), 32'd0);
    chk("rst_cnt", 32'(combo_cnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_code", 32'(err_code), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // type 00 is disabled: beat ignored
    pulses = 0;
    drive(2'b00, 8'hF0, 4'h0);
    chk("off_valid", 32'(pulses), 32'd0);
    chk("off_err", 32'(err), 32'd0);

    // S1 full stream, with one idle gap
    do_clr();
    first_idx = '0;
    last_idx  = '0;
    foreach (pats[n]) begin
      if (n == 10) drive(2'b01, 8'h00, 4'h0);
      drive(2'b01, pats[n], 4'h0);
      if (dec_valid && pulses == 1) first_idx = idx4();
      if (dec_valid) last_idx = idx4();
      if (n == 0) chk("s1_cnt1", 32'(combo_cnt), 32'd1);
    end
    chk("s1_pulses", 32'(pulses), 32'd70);
    chk("s1_first", 32'(first_idx), 32'hFAC);
    chk("s1_last", 32'(last_idx), 32'h688);
    chk("s1_cnt", 32'(combo_cnt), 32'd70);
    chk("s1_done", 32'(done), 32'd1);
    chk("s1_err", 32'(err), 32'd0);
    drive(2'b01, 8'hF0, 4'h0);
    chk("done_ign_v", 32'(dec_valid), 32'd0);
    chk("done_ign_d", 32'(done), 32'd1);
    chk("done_ign_e", 32'(err), 32'd0);

    // S3 full stream
    do_clr();
    chk("clr_cnt", 32'(combo_cnt), 32'd0);
    chk("clr_done", 32'(done), 32'd0);
    ri_bad = 0;
    foreach (pats[n]) begin
      for (int ri = 3; ri >= 1; ri--) begin
        drive(2'b11, pats[n], 4'(1 << ri));
        if (!dec_valid || idx_ri != 2'(ri)) ri_bad++;
      end
    end
    chk("s3_pulses", 32'(pulses), 32'd210);
    chk("s3_ri_seq", 32'(ri_bad), 32'd0);
    chk("s3_last", 32'(idx4()), 32'h688);
    chk("s3_cnt", 32'(combo_cnt), 32'd210);
    chk("s3_done", 32'(done), 32'd1);

    // popcount error on beat 5
    do_clr();
    for (int n = 0; n < 4; n++) drive(2'b01, pats[n], 4'h0);
    drive(2'b01, 8'hF8, 4'h0);
    chk("pop_valid", 32'(dec_valid), 32'd0);
    chk("pop_err", 32'(err), 32'd1);
    chk("pop_code", 32'(err_code), 32'd1);
    chk("pop_cnt", 32'(combo_cnt), 32'd4);

    // RLSS error then later order error
    do_clr();
    drive(2'b11, 8'hF0, 4'b1000);
    drive(2'b11, 8'hF0, 4'b0001);
    chk("rlss_code", 32'(err_code), 32'd2);
    chk("rlss_err", 32'(err), 32'd1);
    drive(2'b11, 8'hF0, 4'b1000);
    chk("rlss_hold", 32'(err_code), 32'd2);
    chk("rlss_cnt", 32'(combo_cnt), 32'd1);

    // repeated F0 in S1
    do_clr();
    drive(2'b01, 8'hF0, 4'h0);
    drive(2'b01, 8'hF0, 4'h0);
    chk("rep_code", 32'(err_code), 32'd3);
    chk("rep_cnt", 32'(combo_cnt), 32'd1);

    // type change mid-run
    do_clr();
    drive(2'b01, 8'hF0, 4'h0);
    drive(2'b01, 8'hE8, 4'h0);
    drive(2'b11, 8'hE4, 4'b1000);
    chk("type_code", 32'(err_code), 32'd3);
    chk("type_cnt", 32'(combo_cnt), 32'd2);

    // clr with a beat in the same cycle
    do_clr();
    drive(2'b01, 8'hF0, 4'h0);
    clr = 1'b1;
    drive(2'b01, 8'hE8, 4'h0);
    clr = 1'b0;
    chk("clrbeat_v", 32'(dec_valid), 32'd0);
    chk("clrbeat_cnt", 32'(combo_cnt), 32'd0);
    drive(2'b01, 8'hF0, 4'h0);
    chk("clrbeat_f0", 32'(combo_cnt), 32'd1);

    // async reset at beat 30, resume mid-stream, then restart
    do_clr();
    for (int n = 0; n < 29; n++) drive(2'b01, pats[n], 4'h0);
    chk("pre_rst_cnt", 32'(combo_cnt), 32'd29);
    rst = 1'b0;
    #2;
    chk("arst_cnt", 32'(combo_cnt), 32'd0);
    chk("arst_idx", 32'(idx4()), 32'd0);
    chk("arst_valid", 32'(dec_valid), 32'd0);
    DSSS = 8'h00;
    #1;
    rst = 1'b1;
    drive(2'b01, pats[29], 4'h0);
    chk("resume_code", 32'(err_code), 32'd3);
    chk("resume_cnt", 32'(combo_cnt), 32'd0);
    do_clr();
    foreach (pats[n]) drive(2'b01, pats[n], 4'h0);
    chk("restart_p", 32'(pulses), 32'd70);
    chk("restart_d", 32'(done), 32'd1);
    chk("restart_c", 32'(combo_cnt), 32'd70);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/spare_sig_checker.md
# spare_sig_checker

Receive-side checker for the spare-structure signature stream. Consumes the DSSS/RLSS pattern stream emitted by the spare-structure signal generator and decodes each pattern back into bit indices (i, j, k, p, ri). Verifies popcount, RLSS legality and strict generation order, counts combinations, and flags completion or the first protocol error. Sits directly downstream of the generator in the redundancy-analysis datapath; also serves as an in-system self-check.

## Interface
- CNT_W, 8, width of the combination counter; must hold 210.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous clear; returns the block to IDLE and zeroes all state.
- spare_struct_type  input  2  01/10 = S1/S2 (DSSS only), 11 = S3 (DSSS + RLSS), 00 = disabled.
- DSSS  input  8  pattern word; exactly four bits set when valid.
- RLSS  input  4  row-line spare select; S3 only, one-hot in bits 3..1, bit 0 always 0.
- dec_valid  output  1  one-cycle pulse; decoded indices valid.
- idx_i, idx_j, idx_k, idx_p  output  3 each  set-bit positions of DSSS, i > j > k > p.
- idx_ri  output  2  set-bit position of RLSS (1..3); 0 in S1/S2.
- combo_cnt  output  CNT_W  number of accepted patterns.
- done  output  1  sticky; full sequence received without error.
- err  output  1  sticky; protocol violation detected.
- err_code  output  2  00 none, 01 popcount, 10 RLSS illegal, 11 order/type violation.

## Operation
- Input beat: any cycle with DSSS != 0 while spare_struct_type != 00. DSSS == 0 cycles are idle and ignored (covers the generator's reset-release gap).
- FSM states: IDLE, RUN, DONE, ERR.
  - IDLE: latch spare_struct_type on first beat -> RUN; type 00 keeps IDLE.
  - RUN: check each beat. Pass -> dec_valid, combo_cnt+1. Last expected beat -> DONE. Fail -> ERR.
  - DONE/ERR: absorbing; inputs ignored. Exit only via rst or clr.
- Checks, priority high to low: popcount(DSSS) != 4 -> 01; RLSS illegal -> 10 (S3: not one-hot in 3..1 or bit 0 set; S1/S2: RLSS != 0); order/type -> 11.
- Order rule S1/S2: each DSSS, unsigned, strictly less than the previous one; first must be 8'hF0.
- Order rule S3: each DSSS is repeated three times with ri = 3, 2, 1. A new DSSS is allowed only after ri = 1 and must be strictly less than the previous one. First beat must be F0/1000.
- spare_struct_type change while in RUN -> err_code 11.
- Expected length: 70 beats (S1/S2), 210 beats (S3). Final beat is 8'h0F (S3: with RLSS 0010); done asserts on it.
- A beat arriving in DONE is ignored; done stays asserted and no error is raised.
- On error: no dec_valid on the failing beat, combo_cnt frozen, err_code holds the first error only.

## Timing
- Reset (rst low, asynchronous) and clr: all outputs 0, state IDLE, previous-pattern register 0.
- Latency: beat at edge N -> dec_valid, indices and combo_cnt update visible after edge N+1.
- done/err assert in the same cycle as the dec_valid (or suppressed dec_valid) of the deciding beat.
- Back-to-back beats every cycle must be accepted; no backpressure.
- rst mid-run: immediate return to IDLE. A stream that resumes mid-sequence then fails the first-beat check (code 11).
- clr and a beat in the same cycle: clr wins and the beat is dropped.

## Structure
- Shared package: S1/S2/S3 encodings, CNT_S12 = 70, CNT_S3 = 210, FIRST_DSSS = 8'hF0, LAST_DSSS = 8'h0F, err_code constants, FSM state enum.
- One sub-module, dsss_index_extract: combinational. Input DSSS, outputs four descending set-bit indices and a popcount.

## Test plan
- S1, full generator stream: 70 dec_valid pulses. First indices 7/6/5/4, last 3/2/1/0. combo_cnt = 70, done = 1, err = 0.
- S3, full stream: 210 pulses with ri cycling 3, 2, 1. combo_cnt = 210, done = 1.
- Inject DSSS = 8'hF8 (five bits) as beat 5 in S1: err = 1, err_code = 01, combo_cnt stays 4.
- S3, RLSS = 0001 on beat 2: err_code = 10, and err_code does not change when a later order error follows.
- S1, repeat beat 8'hF0 twice: err_code = 11. Separately, switch type S1 -> S3 mid-run: err_code = 11.
- Assert rst low for one cycle at beat 30: outputs clear asynchronously. Restart from F0 completes with done = 1 after 70 beats.
